// File: rtl/ad_ip_jesd204_tpl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_pkg
// Purpose  : Shared definitions for the JESD204 transport-layer blocks:
//            FSM state encoding, derived framing parameters (F, FPB, DPW)
//            and a parameter legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ad_ip_jesd204_tpl_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ARM  = 2'd1;
  localparam logic [1:0] STATE_RUN  = 2'd2;

  // Octets per frame per lane: F = M*S*NP / (8*L)
  function automatic int calc_f(input int l, input int m, input int s, input int np);
    return (m * s * np) / (8 * l);
  endfunction

  // Frames carried in one beat of one lane
  function automatic int calc_fpb(input int opb, input int f);
    return (f > 0) ? (opb / f) : 0;
  endfunction

  // Samples per channel per beat
  function automatic int calc_dpw(input int fpb, input int s);
    return fpb * s;
  endfunction

  function automatic bit params_legal(input int l, input int m, input int s,
                                      input int np, input int opb);
    int f;
    if (l < 1 || m < 1 || s < 1 || opb < 1) return 1'b0;
    if (np != 12 && np != 16) return 1'b0;
    if (((m * s * np) % (8 * l)) != 0) return 1'b0;
    f = calc_f(l, m, s, np);
    if (f < 1) return 1'b0;
    if ((opb % f) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_framer_if
// Purpose  : Valid/ready beat stream used for both the sample input and the
//            link-side output of the DAC framer.
// Ports    : valid, ready, data[DATA_WIDTH-1:0]
//            master drives valid/data, slave drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface ad_ip_jesd204_tpl_dac_framer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_pack.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_pack
// Purpose  : Combinational channel masking and sample-to-lane octet mapping.
// Ports    : sample_data  in  M*DPW*16  channel m sample k at [16*(m*DPW+k)+:16]
//            enable       in  M         per-channel enable (0 = zero samples)
//            lane_data    out L*8*OPB   lane l at [l*8*OPB +: 8*OPB]
// Revision : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_pack
  import ad_ip_jesd204_tpl_pkg::*;
#(
  parameter int NUM_LANES         = 4,
  parameter int NUM_CHANNELS      = 2,
  parameter int SAMPLES_PER_FRAME = 1,
  parameter int BITS_PER_SAMPLE   = 16,
  parameter int OCTETS_PER_BEAT   = 4
) (
  input  logic [NUM_CHANNELS*calc_dpw(calc_fpb(OCTETS_PER_BEAT, calc_f(NUM_LANES, NUM_CHANNELS, SAMPLES_PER_FRAME, BITS_PER_SAMPLE)), SAMPLES_PER_FRAME)*16-1:0] sample_data,
  input  logic [NUM_CHANNELS-1:0]                   enable,
  output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0]    lane_data
);
  localparam int F   = calc_f(NUM_LANES, NUM_CHANNELS, SAMPLES_PER_FRAME, BITS_PER_SAMPLE);
  localparam int FPB = calc_fpb(OCTETS_PER_BEAT, F);
  localparam int DPW = calc_dpw(FPB, SAMPLES_PER_FRAME);
  localparam int NP  = BITS_PER_SAMPLE;
  localparam int FW  = F * NUM_LANES * 8;  // frame vector width = M*S*NP

  // All frame vectors of one beat, frame f at [f*FW +: FW]; MSB holds the
  // first sample of the frame.
  logic [FPB*FW-1:0] w_frame;

  for (genvar f = 0; f < FPB; f++) begin : g_frame
    for (genvar m = 0; m < NUM_CHANNELS; m++) begin : g_chan
      for (genvar s = 0; s < SAMPLES_PER_FRAME; s++) begin : g_samp
        localparam int K   = f * SAMPLES_PER_FRAME + s;
        localparam int P   = m * SAMPLES_PER_FRAME + s;
        localparam int SRC = 16 * (m * DPW + K);
        assign w_frame[f*FW + FW-1 - P*NP -: NP] =
          enable[m] ? sample_data[SRC + 16 - NP +: NP] : '0;
        // Samples are MSB-justified; the low bits are not transmitted at NP=12.
        if (NP < 16) begin : g_lsb
          logic w_unused_lsb;
          assign w_unused_lsb = ^sample_data[SRC +: 16 - NP];
        end
      end
    end
    // Frame octet j (0 = most significant) -> lane j/F, lane octet f*F + j%F.
    for (genvar j = 0; j < F * NUM_LANES; j++) begin : g_oct
      assign lane_data[(j / F)*8*OCTETS_PER_BEAT + 8*(f*F + (j % F)) +: 8] =
        w_frame[f*FW + FW-1 - 8*j -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_dac_framer
// Purpose  : JESD204 transport-layer framer (DAC path). Arms on link_ready,
//            packs one input beat per cycle into lane octets, fills
//            underflowed beats with zeros or the previous beat.
// Ports    : clk, reset        clock, synchronous active-high reset
//            s_if  (slave)     sample beats in, ready = RUN && link ready
//            link_if (master)  lane beats out, registered, 1-cycle latency
//            enable            per-channel enable
//            cfg_unf_mode      0 = zero fill, 1 = repeat last beat
//            underflow         one-cycle pulse per filled beat
//            underflow_count   saturating filled-beat count
// Revision : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_framer
  import ad_ip_jesd204_tpl_pkg::*;
#(
  parameter int NUM_LANES         = 4,
  parameter int NUM_CHANNELS      = 2,
  parameter int SAMPLES_PER_FRAME = 1,
  parameter int BITS_PER_SAMPLE   = 16,
  parameter int OCTETS_PER_BEAT   = 4,
  parameter int ARM_DELAY         = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ad_ip_jesd204_tpl_dac_framer_if.slave  s_if,
  ad_ip_jesd204_tpl_dac_framer_if.master link_if,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    cfg_unf_mode,
  output logic                    underflow,
  output logic [31:0]             underflow_count
);
  localparam int LINK_WIDTH = NUM_LANES * 8 * OCTETS_PER_BEAT;
  localparam int ARM_CNT_W  = (ARM_DELAY > 1) ? $clog2(ARM_DELAY + 1) : 1;

  if (!params_legal(NUM_LANES, NUM_CHANNELS, SAMPLES_PER_FRAME,
                    BITS_PER_SAMPLE, OCTETS_PER_BEAT)) begin : g_param_error
    $error("ad_ip_jesd204_tpl_dac_framer: illegal L/M/S/NP/OPB combination");
  end

  logic [1:0]            r_state;
  logic [ARM_CNT_W-1:0]  r_arm_cnt;
  logic                  r_link_valid;
  logic [LINK_WIDTH-1:0] r_link_data;
  logic                  r_underflow;
  logic [31:0]           r_underflow_count;

  logic                  w_s_ready;
  logic                  w_xfer;
  logic                  w_produce;
  logic [ARM_CNT_W-1:0]  w_arm_next;
  logic [LINK_WIDTH-1:0] w_packed;
  logic [LINK_WIDTH-1:0] w_beat;

  ad_ip_jesd204_tpl_dac_pack #(
    .NUM_LANES         (NUM_LANES),
    .NUM_CHANNELS      (NUM_CHANNELS),
    .SAMPLES_PER_FRAME (SAMPLES_PER_FRAME),
    .BITS_PER_SAMPLE   (BITS_PER_SAMPLE),
    .OCTETS_PER_BEAT   (OCTETS_PER_BEAT)
  ) u_pack (
    .sample_data (s_if.data),
    .enable      (enable),
    .lane_data   (w_packed)
  );

  assign w_s_ready  = (r_state == STATE_RUN) && link_if.ready;
  assign w_xfer     = s_if.valid && w_s_ready;
  // Every RUN cycle with the link ready emits a beat, real or filled.
  assign w_produce  = w_s_ready;
  assign w_arm_next = r_arm_cnt + 1'b1;

  // The output register only changes on produced beats, so it doubles as
  // the last-beat store for repeat fill.
  always_comb begin
    w_beat = '0;
    if (w_xfer) begin
      w_beat = w_packed;
    end else if (cfg_unf_mode) begin
      w_beat = r_link_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= STATE_IDLE;
      r_arm_cnt         <= '0;
      r_link_valid      <= 1'b0;
      r_link_data       <= '0;
      r_underflow       <= 1'b0;
      r_underflow_count <= '0;
    end else begin
      r_link_valid <= w_produce;
      r_underflow  <= w_produce && !w_xfer;
      if (w_produce) begin
        r_link_data <= w_beat;
        if (!w_xfer && (r_underflow_count != 32'hFFFF_FFFF)) begin
          r_underflow_count <= r_underflow_count + 32'd1;
        end
      end

      case (r_state)
        STATE_IDLE: begin
          if (link_if.ready) begin
            r_arm_cnt <= '0;
            r_state   <= (ARM_DELAY == 0) ? STATE_RUN : STATE_ARM;
          end
        end
        STATE_ARM: begin
          if (!link_if.ready) begin
            r_state <= STATE_IDLE;
          end else begin
            r_arm_cnt <= w_arm_next;
            if (w_arm_next == ARM_CNT_W'(ARM_DELAY)) begin
              r_state <= STATE_RUN;
            end
          end
        end
        STATE_RUN: begin
          if (!link_if.ready) begin
            r_state <= STATE_IDLE;
          end
        end
        default: r_state <= STATE_IDLE;
      endcase
    end
  end

  assign s_if.ready      = w_s_ready;
  assign link_if.valid   = r_link_valid;
  assign link_if.data    = r_link_data;
  assign underflow       = r_underflow;
  assign underflow_count = r_underflow_count;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_ip_jesd204_tpl_dac_framer
// Purpose  : Self-checking bench. DUT A: L=4 M=2 S=1 NP=16 OPB=4 ARM_DELAY=4.
//            DUT B: L=3 M=1 S=2 NP=12 OPB=4 ARM_DELAY=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_ip_jesd204_tpl_dac_framer;

  localparam int A_ARM = 4;

  logic        clk;
  logic        reset_a, reset_b;
  logic [1:0]  enable_a;
  logic        enable_b;
  logic        mode_a, mode_b;
  logic        unf_a, unf_b;
  logic [31:0] cnt_a, cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  ad_ip_jesd204_tpl_dac_framer_if #(.DATA_WIDTH(128)) sa_if ();
  ad_ip_jesd204_tpl_dac_framer_if #(.DATA_WIDTH(128)) la_if ();
  ad_ip_jesd204_tpl_dac_framer_if #(.DATA_WIDTH(128)) sb_if ();
  ad_ip_jesd204_tpl_dac_framer_if #(.DATA_WIDTH(96))  lb_if ();

  ad_ip_jesd204_tpl_dac_framer #(
    .NUM_LANES(4), .NUM_CHANNELS(2), .SAMPLES_PER_FRAME(1),
    .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4), .ARM_DELAY(A_ARM)
  ) dut_a (
    .clk(clk), .reset(reset_a), .s_if(sa_if), .link_if(la_if),
    .enable(enable_a), .cfg_unf_mode(mode_a),
    .underflow(unf_a), .underflow_count(cnt_a)
  );

  ad_ip_jesd204_tpl_dac_framer #(
    .NUM_LANES(3), .NUM_CHANNELS(1), .SAMPLES_PER_FRAME(2),
    .BITS_PER_SAMPLE(12), .OCTETS_PER_BEAT(4), .ARM_DELAY(0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .s_if(sb_if), .link_if(lb_if),
    .enable(enable_b), .cfg_unf_mode(mode_b),
    .underflow(unf_b), .underflow_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-beat scoreboard and reference state for DUT A
  logic [127:0] sb_q[$];
  int           m_st   = 0;   // 0 idle, 1 arm, 2 run
  int           m_cnt  = 0;
  logic [127:0] m_last = '0;
  logic [31:0]  m_ucnt = '0;
  bit           chk_cnt = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane octets straight from the frame layout: frame = {ch0, ch1}, one octet
  // per lane, frame f in lane octet f.
  function automatic logic [127:0] pack_a(input logic [127:0] d, input logic [1:0] en);
    logic [127:0] r;
    logic [15:0]  c0, c1;
    r = '0;
    for (int f = 0; f < 4; f++) begin
      c0 = en[0] ? d[16*f +: 16]     : 16'h0;
      c1 = en[1] ? d[16*(4+f) +: 16] : 16'h0;
      r[8*f +: 8]      = c0[15:8];
      r[32 + 8*f +: 8] = c0[7:0];
      r[64 + 8*f +: 8] = c1[15:8];
      r[96 + 8*f +: 8] = c1[7:0];
    end
    return r;
  endfunction

  // Frame = {s0[15:4], s1[15:4]} = 3 octets across 3 lanes.
  function automatic logic [127:0] pack_b(input logic [127:0] d);
    logic [127:0] r;
    logic [23:0]  v;
    r = '0;
    for (int f = 0; f < 4; f++) begin
      v = {d[32*f + 4 +: 12], d[32*f + 20 +: 12]};
      r[8*f +: 8]      = v[23:16];
      r[32 + 8*f +: 8] = v[15:8];
      r[64 + 8*f +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic step_a(input logic rst_i, input logic vld, input logic [127:0] d,
                        input logic [1:0] en, input logic mode, input logic lrdy);
    logic         exp_valid, exp_unf;
    logic [127:0] beat;
    @(negedge clk);
    reset_a = rst_i; sa_if.valid = vld; sa_if.data = d;
    enable_a = en; mode_a = mode; la_if.ready = lrdy;
    #1;
    chk("s_ready", sa_if.ready, (m_st == 2) && lrdy);
    exp_valid = 1'b0;
    exp_unf   = 1'b0;
    if (rst_i) begin
      m_st = 0; m_last = '0; m_ucnt = '0;
    end else begin
      if (m_st == 2 && lrdy) begin
        if (vld) begin
          beat = pack_a(d, en);
        end else begin
          beat = mode ? m_last : '0;
          exp_unf = 1'b1;
          if (m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 32'd1;
        end
        m_last = beat;
        sb_q.push_back(beat);
        exp_valid = 1'b1;
      end
      case (m_st)
        0: if (lrdy) begin m_cnt = 0; m_st = 1; end
        1: if (!lrdy) m_st = 0;
           else begin m_cnt++; if (m_cnt == A_ARM) m_st = 2; end
        default: if (!lrdy) m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
    chk("link_valid", la_if.valid, exp_valid);
    if (la_if.valid === 1'b1 && sb_q.size() > 0) chk("beat", la_if.data, sb_q.pop_front());
    if (la_if.valid !== 1'b1) sb_q.delete();
    chk("link_data", la_if.data, m_last);
    chk("underflow", unf_a, exp_unf);
    if (chk_cnt) chk("underflow_count", cnt_a, m_ucnt);
  endtask

  logic [127:0] rd;
  logic [127:0] d1;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    sa_if.valid = 1'b0; sa_if.data = '0; la_if.ready = 1'b0;
    sb_if.valid = 1'b0; sb_if.data = '0; lb_if.ready = 1'b0;
    enable_a = 2'b11; enable_b = 1'b1; mode_a = 1'b0; mode_b = 1'b0;

    // ---------------- DUT B: NP=12, S=2, immediate arming ----------------
    @(negedge clk);
    reset_b = 1'b0; lb_if.ready = 1'b1; sb_if.valid = 1'b1;
    sb_if.data = {4{16'hDEF0, 16'hABC0}};
    #1 chk("b_s_ready_idle", sb_if.ready, 1'b0);
    @(posedge clk); #1;
    chk("b_valid_idle", lb_if.valid, 1'b0);
    chk("b_data_reset", lb_if.data, '0);
    @(negedge clk); #1;
    chk("b_s_ready_run", sb_if.ready, 1'b1);
    @(posedge clk); #1;
    chk("b_valid", lb_if.valid, 1'b1);
    chk("b_pack_const", lb_if.data, 96'hEFEFEFEF_CDCDCDCD_ABABABAB);
    @(negedge clk);
    rd = {$urandom, $urandom, $urandom, $urandom};
    sb_if.data = rd;
    @(posedge clk); #1;
    chk("b_pack_rand", lb_if.data, pack_b(rd));
    @(negedge clk);
    sb_if.valid = 1'b0;
    @(posedge clk); #1;
    chk("b_unf_pulse", unf_b, 1'b1);
    chk("b_unf_count", cnt_b, 32'd1);
    chk("b_zero_fill", lb_if.data, '0);
    @(negedge clk);
    lb_if.ready = 1'b0; reset_b = 1'b1;

    // ---------------- DUT A ----------------
    d1 = {{4{16'hABCD}}, {4{16'h1234}}};
    step_a(1'b1, 1'b0, '0, 2'b11, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, '0, 2'b11, 1'b0, 1'b0);
    // 1 cycle IDLE->ARM plus 4 counted ARM cycles, transfer on the 6th
    repeat (5) step_a(1'b0, 1'b1, d1, 2'b11, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, d1, 2'b11, 1'b0, 1'b1);
    chk("a_pack_const", la_if.data, 128'hCDCDCDCD_ABABABAB_34343434_12121212);
    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b1);
    end
    // zero fill
    repeat (3) step_a(1'b0, 1'b0, '0, 2'b11, 1'b0, 1'b1);
    chk("a_unf_count_3", cnt_a, 32'd3);
    // repeat fill
    rd = {$urandom, $urandom, $urandom, $urandom};
    step_a(1'b0, 1'b1, rd, 2'b11, 1'b1, 1'b1);
    repeat (3) step_a(1'b0, 1'b0, '0, 2'b11, 1'b1, 1'b1);
    chk("a_repeat_beat", la_if.data, pack_a(rd, 2'b11));
    // channel 1 masked
    step_a(1'b0, 1'b1, {{4{16'hFFFF}}, {4{16'h1234}}}, 2'b01, 1'b0, 1'b1);
    chk("a_mask_const", la_if.data, 128'h00000000_00000000_34343434_12121212);
    // link_ready drop, aborted arm at count 2, full re-arm
    step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b0);
    repeat (3) step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b0);
    repeat (5) step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b1);
    rd = {$urandom, $urandom, $urandom, $urandom};
    step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b1);
    // counter saturation
    force dut_a.r_underflow_count = 32'hFFFF_FFFE;
    m_ucnt  = 32'hFFFF_FFFE;
    chk_cnt = 1'b0;
    step_a(1'b0, 1'b0, '0, 2'b11, 1'b0, 1'b1);
    release dut_a.r_underflow_count;
    chk_cnt = 1'b1;
    repeat (2) step_a(1'b0, 1'b0, '0, 2'b11, 1'b0, 1'b1);
    chk("a_unf_count_sat", cnt_a, 32'hFFFF_FFFF);
    // reset with a transfer pending: beat dropped, back to IDLE
    rd = {$urandom, $urandom, $urandom, $urandom};
    step_a(1'b1, 1'b1, rd, 2'b11, 1'b0, 1'b1);
    chk("a_rst_count", cnt_a, 32'd0);
    step_a(1'b0, 1'b1, rd, 2'b11, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
